// File: rtl/kbd_event_fifo.sv
// Debounces the scanner key code and emits press/release events into a small valid/ready FIFO.
// An event is enqueued DEBOUNCE_CYCLES+1 edges after a code change lands; a full FIFO drops events (sticky overflow) without stalling.
module kbd_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] scan_code_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [4:0] evt_data_o,
  output logic       overflow_o,
  input  logic       clr_ovf_i,
  output logic       key_down_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        state;
  logic [7:0]    scan_q;
  logic [7:0]    scan_prev;
  logic [7:0]    held_code;
  logic [3:0]    cur_key;
  logic [CW-1:0] stable_cnt;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic       scan_valid;
  logic [3:0] scan_key;
  logic       changed;
  logic       stable;
  logic       press_evt;
  logic       rel_evt;
  logic       evt_push;
  logic [4:0] push_dat;

  assign scan_valid = $onehot(scan_q[7:4]) && $onehot(scan_q[3:0]);
  assign scan_key   = {oh_idx(scan_q[7:4]), oh_idx(scan_q[3:0])};
  assign changed    = (scan_q != scan_prev);
  // A change seen this cycle overrides a saturated counter that has not yet been cleared.
  assign stable     = !changed && (stable_cnt == CNT_MAX);
  assign press_evt  = (state == PRESS_WAIT) && stable;
  assign rel_evt    = (state == RELEASE_WAIT) && (scan_q != held_code) && stable;
  assign evt_push   = press_evt || rel_evt;
  assign push_dat   = {press_evt, cur_key};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_q     <= 8'h00;
      scan_prev  <= 8'h00;
      stable_cnt <= '0;
    end else begin
      scan_q    <= scan_code_i;
      scan_prev <= scan_q;
      if (changed)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cur_key    <= 4'h0;
      held_code  <= 8'h00;
      key_down_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_valid) begin
            state     <= PRESS_WAIT;
            cur_key   <= scan_key;
            held_code <= scan_q;
          end
        end
        PRESS_WAIT: begin
          if (changed) begin
            state <= IDLE;
          end else if (stable) begin
            state      <= HELD;
            key_down_o <= 1'b1;
          end
        end
        HELD: begin
          if (scan_q != held_code)
            state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (scan_q == held_code) begin
            state <= HELD;
          end else if (stable) begin
            state      <= IDLE;
            key_down_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic full;
  logic pop;
  logic do_push;

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid_o = (wr_ptr != rd_ptr);
  assign evt_data_o  = mem[rd_ptr[AW-1:0]];
  assign pop         = evt_valid_o && evt_ready_i;
  // A pop frees the slot this same edge, so a push into a full FIFO is still accepted.
  assign do_push     = evt_push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 5'h00;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (evt_push && full && !pop)
        overflow_o <= 1'b1;
      else if (clr_ovf_i)
        overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo: vector table of key codes plus directed bounce, overflow and reset sequences.
module tb_kbd_event_fifo;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] scan_code_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [4:0] evt_data_o;
  logic       overflow_o;
  logic       clr_ovf_i;
  logic       key_down_o;

  kbd_event_fifo #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .scan_code_i (scan_code_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_data_o  (evt_data_o),
    .overflow_o  (overflow_o),
    .clr_ovf_i   (clr_ovf_i),
    .key_down_o  (key_down_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int n_pops = 0;
  logic [4:0] exp_q[$];
  logic [4:0] sb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted head is compared against the oldest expected event.
  always @(negedge clk_i) begin
    #2;
    if (rst_ni && evt_valid_o && evt_ready_i) begin
      n_pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %b, expected no event", evt_data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (evt_data_o !== sb_exp) begin
          errors++;
          $display("FAIL sb_data: got %b, expected %b", evt_data_o, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [7:0] code, input int n);
    scan_code_i = code;
    repeat (n) @(negedge clk_i);
  endtask

  // Index k of the first negedge (after sampling edge N+k) where evt_valid_o is seen; -1 if none in 40 cycles.
  task automatic measure(output int first_k);
    first_k = -1;
    @(posedge clk_i);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (evt_valid_o && first_k < 0) first_k = k;
    end
  endtask

  typedef struct {
    logic [7:0] code;
    logic       ok;
    logic [3:0] key;
  } vec_t;

  vec_t vecs[7];
  int   k;
  int   nb;
  int   pops0;

  initial begin
    vecs[0] = '{code: 8'b0010_0100, ok: 1'b1, key: 4'h6};
    vecs[1] = '{code: 8'b0001_0001, ok: 1'b1, key: 4'h0};
    vecs[2] = '{code: 8'b1000_1000, ok: 1'b1, key: 4'hF};
    vecs[3] = '{code: 8'b0100_0010, ok: 1'b1, key: 4'h9};
    vecs[4] = '{code: 8'b0011_0100, ok: 1'b0, key: 4'h0};
    vecs[5] = '{code: 8'b0001_0011, ok: 1'b0, key: 4'h0};
    vecs[6] = '{code: 8'b0000_0100, ok: 1'b0, key: 4'h0};

    rst_ni      = 1'b0;
    scan_code_i = 8'h00;
    evt_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_key_down", key_down_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_data", evt_data_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Clean press/release of each valid code; invalid codes must stay silent.
    evt_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ok) exp_q.push_back({1'b1, vecs[i].key});
      scan_code_i = vecs[i].code;
      measure(k);
      if (vecs[i].ok) chk("press_latency", k, 17);
      else            chk("invalid_no_event", k, -1);
      chk("key_down_held", key_down_o, vecs[i].ok);
      if (vecs[i].ok) exp_q.push_back({1'b0, vecs[i].key});
      scan_code_i = 8'h00;
      measure(k);
      if (vecs[i].ok) chk("release_latency", k, 17);
      else            chk("invalid_no_event_rel", k, -1);
      chk("key_down_released", key_down_o, 0);
    end

    // Bounce: no event while toggling, exactly one press once settled.
    nb = 0;
    pops0 = n_pops;
    for (int p = 0; p < 12; p++) begin
      scan_code_i = p[0] ? 8'h00 : 8'b0001_0001;
      repeat (5) begin
        @(negedge clk_i);
        if (evt_valid_o) nb++;
      end
    end
    chk("bounce_quiet", nb, 0);
    exp_q.push_back(5'b1_0000);
    scan_code_i = 8'b0001_0001;
    measure(k);
    chk("bounce_press_latency", k, 17);
    chk("bounce_one_event", n_pops - pops0, 1);
    exp_q.push_back(5'b0_0000);
    hold(8'h00, 25);

    // Backpressure: six events into a four-entry FIFO.
    evt_ready_i = 1'b0;
    exp_q.push_back(5'b1_0001);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b1_0111);
    exp_q.push_back(5'b0_0111);
    hold(8'b0001_0010, 20);
    hold(8'h00, 20);
    chk("ovf_head_first", evt_data_o, 5'b1_0001);
    chk("ovf_not_yet", overflow_o, 0);
    hold(8'b0010_1000, 20);
    hold(8'h00, 20);
    hold(8'b1000_0001, 20);
    hold(8'h00, 20);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_valid", evt_valid_o, 1);
    chk("ovf_head_stable", evt_data_o, 5'b1_0001);
    evt_ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    evt_ready_i = 1'b0;
    chk("ovf_drained", evt_valid_o, 0);
    chk("ovf_sb_drained", exp_q.size(), 0);
    chk("ovf_sticky", overflow_o, 1);
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);

    // Push and pop on the same edge while full.
    exp_q.push_back(5'b1_1010);
    exp_q.push_back(5'b0_1010);
    exp_q.push_back(5'b1_1101);
    exp_q.push_back(5'b0_1101);
    exp_q.push_back(5'b1_0100);
    hold(8'b0100_0100, 20);
    hold(8'h00, 20);
    hold(8'b1000_0010, 20);
    hold(8'h00, 20);
    chk("full_valid", evt_valid_o, 1);
    scan_code_i = 8'b0010_0001;
    @(posedge clk_i);
    repeat (17) @(negedge clk_i);
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    evt_ready_i = 1'b0;
    chk("pushpop_no_ovf", overflow_o, 0);
    chk("pushpop_head", evt_data_o, 5'b0_1010);
    evt_ready_i = 1'b1;
    hold(8'b0010_0001, 10);
    exp_q.push_back(5'b0_0100);
    hold(8'h00, 25);
    chk("pushpop_empty", evt_valid_o, 0);
    chk("pushpop_no_ovf_end", overflow_o, 0);

    // Reset while full, overflowed and mid release-debounce.
    evt_ready_i = 1'b0;
    hold(8'b0001_0100, 20);
    hold(8'h00, 20);
    hold(8'b0001_1000, 20);
    hold(8'h00, 20);
    hold(8'b1000_1000, 20);
    chk("pre_rst_ovf", overflow_o, 1);
    chk("pre_rst_key_down", key_down_o, 1);
    hold(8'h00, 5);
    scan_code_i = 8'b1000_1000;
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_valid", evt_valid_o, 0);
    chk("arst_key_down", key_down_o, 0);
    chk("arst_overflow", overflow_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    evt_ready_i = 1'b1;
    exp_q.push_back(5'b1_1111);
    measure(k);
    chk("post_rst_press_latency", k, 17);
    exp_q.push_back(5'b0_1111);
    scan_code_i = 8'h00;
    measure(k);
    chk("post_rst_release_latency", k, 17);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
